uart_cmd_tx: RTL and testbench
==============================

Name: uart_cmd_tx

Overview:
Transmit-side counterpart to the control module's UART command receiver. Accepts a command request (opcode, argument, payload length) and serializes it as 8N1 UART bytes on tx_out. The byte order is opcode, argument, then payload bytes fetched from a synchronous read buffer. Used by host-side/loopback logic and benches to drive frame data into the display controller without the debugger string path.

Parameters:
UART_TICKS_PER_BIT, 20, clk_in cycles per UART bit (2.5 Mbaud at 50 MHz); must be >= 4
UART_TICKS_WIDTH, 5, width of bit-tick counter
BUF_ADDR_WIDTH, 12, payload buffer address width; max payload = 2^BUF_ADDR_WIDTH bytes

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high when idle and able to accept
cmd_opcode  input  8  first byte sent (e.g. "L", "R", "b")
cmd_arg  input  8  second byte sent (row / brightness value)
cmd_len  input  BUF_ADDR_WIDTH+1  payload byte count; 0 = header only
buf_addr  output  BUF_ADDR_WIDTH  payload read address
buf_data  input  8  payload byte, valid exactly 1 cycle after buf_addr changes
tx_out  output  1  UART serial line, idle high
tx_busy  output  1  high from accept through the final stop bit
frame_done  output  1  one-cycle pulse at frame completion
bytes_sent  output  8  running count of bytes transmitted, wraps at 255

Behaviour:
- Reset (reset=0, async): tx_out=1, cmd_ready=0 while reset is held, then 1 in the first cycle after release. tx_busy=0, frame_done=0, buf_addr=0, bytes_sent=0, FSM=IDLE. A reset mid-frame aborts immediately. No partial byte is resumed.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch opcode, arg, and len_eff = min(cmd_len, 2^BUF_ADDR_WIDTH). Set buf_addr=0 and go to START with byte=opcode.
  - START: tx_out=0.
  - DATA: bits 0..7, LSB first.
  - STOP: tx_out=1.
  - After STOP: if more bytes remain, go to START with the next byte. Otherwise return to IDLE.
- Bit timing: every bit, including start and stop, lasts exactly UART_TICKS_PER_BIT cycles. tx_out goes low the cycle after acceptance. There is no inter-byte gap: the next start bit follows the last stop cycle directly.
- Byte sequence: opcode, arg, buf[0] .. buf[len_eff-1]. Frame length is (2+len_eff)*10*UART_TICKS_PER_BIT cycles.
- Buffer fetch:
  - During the STOP bit of byte k (k>=1), buf_addr holds the index of the next payload byte.
  - buf_data is sampled on the last STOP cycle.
  - buf_addr increments after each sample. It is never driven past len_eff-1; for len_eff=0 it stays 0.
- cmd_valid is ignored while not in IDLE. cmd_opcode, cmd_arg, and cmd_len may change freely after acceptance.
- tx_busy=1 from the cycle after acceptance until the last STOP cycle inclusive.
- frame_done pulses in the cycle the FSM re-enters IDLE. cmd_ready=1 in that same cycle, so a back-to-back command may be accepted there and its start bit follows one cycle later.
- bytes_sent increments by 1 at each completed stop bit and wraps 255->0. It is not cleared between frames.
- Arithmetic: the payload counter is BUF_ADDR_WIDTH+1 bits so that len = 2^BUF_ADDR_WIDTH is representable.

Test Plan:
- Reset, then idle for 100 cycles -> tx_out=1, cmd_ready=1, tx_busy=0, frame_done never pulses.
- opcode=0x62 ("b"), arg=0x35, len=0 -> tx_out shows 2 frames over 400 cycles. A bench UART RX at 20 ticks decodes 0x62, 0x35. frame_done pulses at cycle 400 after accept; bytes_sent=2.
- opcode="L", arg=0x07, len=3, buffer {0x11,0x22,0x33} -> decoded bytes 0x4C, 0x07, 0x11, 0x22, 0x33 over 1000 cycles. buf_addr sequence is 0,1,2 and never 3.
- Hold cmd_valid=1 continuously with two commands -> the second start bit begins exactly 1 cycle after the first frame_done. No extra idle bits; decoded stream is contiguous.
- Assert reset=0 mid-DATA of byte 2 -> tx_out=1 in the same cycle, tx_busy=0, bytes_sent=0. After release a new command transmits correctly from its opcode.
- len=4097 with BUF_ADDR_WIDTH=12 -> clamped to 4096 payload bytes. buf_addr ends at 4095; bytes_sent wraps (4098 mod 256 = 2).

Source files
------------

// File: rtl/uart_cmd_tx.sv
// Serialises an opcode/argument/payload command as back-to-back 8N1 UART bytes.
// Payload bytes come from a synchronous buffer with one cycle of read latency.
module uart_cmd_tx #(
  parameter int UART_TICKS_PER_BIT = 20,
  parameter int UART_TICKS_WIDTH   = 5,
  parameter int BUF_ADDR_WIDTH     = 12
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [7:0]                cmd_opcode,
  input  logic [7:0]                cmd_arg,
  input  logic [BUF_ADDR_WIDTH:0]   cmd_len,
  output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
  input  logic [7:0]                buf_data,
  output logic                      tx_out,
  output logic                      tx_busy,
  output logic                      frame_done,
  output logic [7:0]                bytes_sent
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int LW = BUF_ADDR_WIDTH + 1;
  localparam int BW = BUF_ADDR_WIDTH + 2;
  localparam logic [UART_TICKS_WIDTH-1:0] TICK_LAST = UART_TICKS_WIDTH'(UART_TICKS_PER_BIT - 1);
  localparam logic [UART_TICKS_WIDTH-1:0] TICK_ONE  = UART_TICKS_WIDTH'(1);
  localparam logic [LW-1:0]               LEN_MAX   = LW'(1) << BUF_ADDR_WIDTH;
  localparam logic [LW-1:0]               LEN_ONE   = LW'(1);
  localparam logic [BW-1:0]               IDX_ONE   = BW'(1);
  localparam logic [BUF_ADDR_WIDTH-1:0]   ADDR_ONE  = BUF_ADDR_WIDTH'(1);

  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] len);
    return (len > LEN_MAX) ? LEN_MAX : len;
  endfunction

  logic [1:0]                  state;
  logic [UART_TICKS_WIDTH-1:0] tick;
  logic [2:0]                  bit_idx;
  logic [BW-1:0]               byte_idx;
  logic                        armed;
  logic [7:0]                  shift;
  logic [7:0]                  arg_q;
  logic [LW-1:0]               len_q;

  logic accept;
  logic tick_end;
  logic more;
  logic addr_room;

  assign cmd_ready = armed && (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick_end  = (tick == TICK_LAST);
  // byte_idx 0 is the opcode, 1 the argument, 2.. the payload; the last index is len+1
  assign more      = (byte_idx != (BW'(len_q) + IDX_ONE));
  assign addr_room = ((LW'(buf_addr) + LEN_ONE) < len_q);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      tick       <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      armed      <= 1'b0;
      buf_addr   <= '0;
      tx_out     <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      bytes_sent <= '0;
    end else begin
      armed      <= 1'b1;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state    <= S_START;
            tick     <= '0;
            byte_idx <= '0;
            buf_addr <= '0;
            tx_out   <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (tick_end) begin
            state   <= S_DATA;
            tick    <= '0;
            bit_idx <= '0;
            tx_out  <= shift[0];
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        S_DATA: begin
          if (tick_end) begin
            tick <= '0;
            if (bit_idx == 3'd7) begin
              state  <= S_STOP;
              tx_out <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_out  <= shift[bit_idx + 3'd1];
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        default: begin
          if (tick_end) begin
            tick       <= '0;
            bytes_sent <= bytes_sent + 8'd1;
            if (more) begin
              state    <= S_START;
              tx_out   <= 1'b0;
              byte_idx <= byte_idx + IDX_ONE;
              // a payload byte was just sampled; advance but never past len-1
              if ((byte_idx != '0) && addr_room) begin
                buf_addr <= buf_addr + ADDR_ONE;
              end
            end else begin
              state      <= S_IDLE;
              tx_busy    <= 1'b0;
              frame_done <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (state == S_IDLE && accept) begin
      shift <= cmd_opcode;
      arg_q <= cmd_arg;
      len_q <= sat_len(cmd_len);
    end else if (state == S_STOP && tick_end && more) begin
      shift <= (byte_idx == '0) ? arg_q : buf_data;
    end
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Directed bench for uart_cmd_tx: a 20-tick instance with a decoding monitor
// and a 4-tick, 8-bit-address instance for the length clamp and counter wrap.
module tb_uart_cmd_tx;

  localparam int T   = 20;
  localparam int AW  = 12;
  localparam int FT  = 4;
  localparam int FAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_opcode, cmd_arg;
  logic [AW:0]   cmd_len;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_data;
  logic          tx_out, tx_busy, frame_done;
  logic [7:0]    bytes_sent;

  logic           f_cmd_valid, f_cmd_ready;
  logic [7:0]     f_cmd_opcode, f_cmd_arg;
  logic [FAW:0]   f_cmd_len;
  logic [FAW-1:0] f_buf_addr;
  logic [7:0]     f_buf_data;
  logic           f_tx_out, f_tx_busy, f_frame_done;
  logic [7:0]     f_bytes_sent;

  uart_cmd_tx #(.UART_TICKS_PER_BIT(T), .UART_TICKS_WIDTH(5), .BUF_ADDR_WIDTH(AW)) dut (
    .clk_in(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_arg(cmd_arg), .cmd_len(cmd_len),
    .buf_addr(buf_addr), .buf_data(buf_data), .tx_out(tx_out), .tx_busy(tx_busy),
    .frame_done(frame_done), .bytes_sent(bytes_sent)
  );

  uart_cmd_tx #(.UART_TICKS_PER_BIT(FT), .UART_TICKS_WIDTH(3), .BUF_ADDR_WIDTH(FAW)) dut_fast (
    .clk_in(clk), .reset(reset), .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready),
    .cmd_opcode(f_cmd_opcode), .cmd_arg(f_cmd_arg), .cmd_len(f_cmd_len),
    .buf_addr(f_buf_addr), .buf_data(f_buf_data), .tx_out(f_tx_out), .tx_busy(f_tx_busy),
    .frame_done(f_frame_done), .bytes_sent(f_bytes_sent)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] buf_mem [16];
  always @(posedge clk) buf_data <= buf_mem[buf_addr[3:0]];
  always @(posedge clk) f_buf_data <= f_buf_addr ^ 8'hA5;

  int            st_q[$];
  int            fd_q[$];
  logic [7:0]    dec_q[$];
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] last_addr = '0;
  int            frm_err = 0;
  int            f_max = 0;

  // bench UART receiver: sample mid-bit, record start cycle of each byte
  always begin
    logic [7:0] rx;
    @(negedge clk);
    if (reset === 1'b1 && tx_out === 1'b0) begin
      st_q.push_back(cyc);
      repeat (T / 2) @(negedge clk);
      if (tx_out !== 1'b0) frm_err++;
      for (int b = 0; b < 8; b++) begin
        repeat (T) @(negedge clk);
        rx[b] = tx_out;
      end
      repeat (T) @(negedge clk);
      if (tx_out !== 1'b1) frm_err++;
      dec_q.push_back(rx);
    end
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_q.push_back(cyc);
    if (buf_addr !== last_addr) begin
      addr_q.push_back(buf_addr);
      last_addr = buf_addr;
    end
    if (int'(f_buf_addr) > f_max) f_max = int'(f_buf_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_dec(input string tag, input int base, input int n, input logic [63:0] exp);
    logic [7:0] got;
    chk({tag, "_count"}, dec_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      got = (base + i < dec_q.size()) ? dec_q[base + i] : 8'h00;
      chk($sformatf("%s_byte%0d", tag, i), got, exp[8*(n-1-i) +: 8]);
    end
  endtask

  task automatic send(input logic [7:0] op, input logic [7:0] arg, input logic [AW:0] len,
                      output int acc);
    int n;
    n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", cmd_ready, 1);
    cmd_opcode = op;
    cmd_arg    = arg;
    cmd_len    = len;
    cmd_valid  = 1'b1;
    @(negedge clk);
    acc        = cyc;
    cmd_valid  = 1'b0;
    cmd_opcode = ~op;
    cmd_arg    = ~arg;
    cmd_len    = '0;
  endtask

  task automatic wait_fd(output int fd);
    fd = -1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        fd = cyc;
        break;
      end
    end
    if (fd < 0) chk("frame_done_timeout", 0, 1);
  endtask

  initial begin
    int acc, acc1, fd, fd1, fd2, viol, bd, bs, ba, fd_base;
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = '0; cmd_arg = '0; cmd_len = '0;
    f_cmd_valid = 1'b0; f_cmd_opcode = '0; f_cmd_arg = '0; f_cmd_len = '0;
    for (int i = 0; i < 16; i++) buf_mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_buf_addr", buf_addr, 0);
    chk("rst_bytes_sent", bytes_sent, 0);
    chk("rst_fast_tx_out", f_tx_out, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1);

    fd_base = fd_q.size();
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || cmd_ready !== 1'b1 || tx_busy !== 1'b0) viol++;
    end
    chk("idle_violations", viol, 0);
    chk("idle_frame_done_pulses", fd_q.size() - fd_base, 0);

    // header-only frame
    bd = dec_q.size(); bs = st_q.size();
    send(8'h62, 8'h35, '0, acc);
    chk("b_first_tx_low", tx_out, 0);
    chk("b_busy", tx_busy, 1);
    chk("b_ready_low", cmd_ready, 0);
    wait_fd(fd);
    chk("b_frame_len", fd - acc, 400);
    chk("b_start_cycle", (st_q.size() > bs) ? st_q[bs] : -1, acc);
    chk("b_busy_end", tx_busy, 0);
    chk("b_ready_end", cmd_ready, 1);
    chk("b_bytes_sent", bytes_sent, 2);
    chk_dec("b", bd, 2, {8'h62, 8'h35});

    // three payload bytes from the buffer
    buf_mem[0] = 8'h11; buf_mem[1] = 8'h22; buf_mem[2] = 8'h33; buf_mem[3] = 8'hEE;
    bd = dec_q.size(); ba = addr_q.size();
    send(8'h4C, 8'h07, 13'd3, acc);
    wait_fd(fd);
    chk("L_frame_len", fd - acc, 1000);
    chk("L_bytes_sent", bytes_sent, 7);
    chk_dec("L", bd, 5, {8'h4C, 8'h07, 8'h11, 8'h22, 8'h33});
    chk("L_addr_changes", addr_q.size() - ba, 2);
    chk("L_addr_1", (addr_q.size() > ba) ? addr_q[ba] : 12'hFFF, 1);
    chk("L_addr_2", (addr_q.size() > ba + 1) ? addr_q[ba + 1] : 12'hFFF, 2);
    chk("L_addr_final", buf_addr, 2);

    // back-to-back with cmd_valid held high
    bd = dec_q.size(); bs = st_q.size();
    @(negedge clk);
    cmd_opcode = 8'h41; cmd_arg = 8'h42; cmd_len = '0; cmd_valid = 1'b1;
    @(negedge clk);
    acc1 = cyc;
    cmd_opcode = 8'h43; cmd_arg = 8'h44;
    wait_fd(fd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_fd(fd2);
    chk("btb_frame1_len", fd1 - acc1, 400);
    chk("btb_second_start", (st_q.size() > bs + 2) ? st_q[bs + 2] : -1, fd1 + 1);
    chk("btb_frame_gap", fd2 - fd1, 401);
    chk("btb_bytes_sent", bytes_sent, 11);
    chk_dec("btb", bd, 4, {8'h41, 8'h42, 8'h43, 8'h44});

    // reset in the middle of data bit 2 of the argument byte
    buf_mem[0] = 8'hC3; buf_mem[1] = 8'h3C;
    send(8'h52, 8'h99, 13'd2, acc);
    repeat (269) @(negedge clk);
    chk("mid_tx_bit", tx_out, 0);
    chk("mid_bytes_sent", bytes_sent, 12);
    reset = 1'b0;
    #1;
    chk("abort_tx_out", tx_out, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_bytes_sent", bytes_sent, 0);
    chk("abort_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (300) @(negedge clk);
    buf_mem[0] = 8'h5A;
    bd = dec_q.size(); bs = st_q.size();
    send(8'h4C, 8'h01, 13'd1, acc);
    wait_fd(fd);
    chk("post_frame_len", fd - acc, 600);
    chk("post_start_cycle", (st_q.size() > bs) ? st_q[bs] : -1, acc);
    chk("post_bytes_sent", bytes_sent, 3);
    chk_dec("post", bd, 3, {8'h4C, 8'h01, 8'h5A});
    chk("framing_errors", frm_err, 0);

    // oversized length on the 8-bit-address, 4-tick instance
    @(negedge clk);
    chk("fast_ready", f_cmd_ready, 1);
    f_cmd_opcode = 8'h46; f_cmd_arg = 8'h00; f_cmd_len = 9'd257; f_cmd_valid = 1'b1;
    @(negedge clk);
    acc = cyc;
    f_cmd_valid = 1'b0; f_cmd_len = '0;
    fd = -1;
    for (int n = 0; n < 20000; n++) begin
      @(negedge clk);
      if (f_frame_done === 1'b1) begin
        fd = cyc;
        break;
      end
    end
    chk("fast_frame_len", fd - acc, 258 * 10 * FT);
    chk("fast_bytes_sent_wrap", f_bytes_sent, 2);
    chk("fast_buf_addr_final", f_buf_addr, 255);
    chk("fast_buf_addr_max", f_max, 255);
    chk("fast_busy_end", f_tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
